// File: rtl/irq_nmi_ctrl.sv
// irq_nmi_ctrl: interrupt front-end for the 65C02 core.
// Merges up to 8 active-low IRQ lines and one NMI line into the CPU's irqb/nmib
// inputs. It adds per-channel mask, level/edge mode, fixed priority (lowest index
// wins), vector reporting and acknowledge handshakes.
// Optional nesting (in-service register plus EOI) is enabled by defining IRQ_NEST_EN.
module irq_nmi_ctrl #(
  parameter int          CHANNELS    = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_BASE    = 16'hFFE0
) (
  input  logic                phi2,
  input  logic                res,
  input  logic [CHANNELS-1:0] irqb_in,
  input  logic                nmib_in,
  input  logic                cs,
  input  logic                rwb,
  input  logic [1:0]          reg_addr,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata,
  input  logic                int_ack,
  input  logic                nmi_ack,
  output logic                irqb,
  output logic                nmib,
  output logic [2:0]          vec_idx,
  output logic [15:0]         vec_addr
);

  logic [CHANNELS-1:0]    irq_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] nmi_sync_q;
  logic [CHANNELS-1:0]    irq_s, irq_prev_q;
  logic                   nmi_s, nmi_prev_q;

  logic [CHANNELS-1:0] mask_q, mask_d, mode_q, mode_d, pend_q, pend_d;
  logic [CHANNELS-1:0] act, act_eff, elig, edge_set, edge_clr, ack_clr, wdata_ch;
  logic                nmi_pend_q, nmi_pend_d, nmi_fall;
  logic                irqb_q, irqb_d, nmib_q;
  logic [2:0]          vec_q, vec_d, stat_ins;
  logic                wr_en, wr_mask, wr_mode, wr_pend, ack_ok;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign irq_s    = irq_sync_q[SYNC_STAGES-1];
  assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
  assign wdata_ch = wdata[CHANNELS-1:0];
  assign wr_en    = cs & ~rwb;
  assign wr_mask  = wr_en & (reg_addr == 2'd0);
  assign wr_mode  = wr_en & (reg_addr == 2'd1);
  assign wr_pend  = wr_en & (reg_addr == 2'd2);

  assign act      = pend_q & mask_q;
  assign act_eff  = act & elig;
  assign ack_ok   = int_ack & (|act_eff);
  assign edge_set = irq_prev_q & ~irq_s;
  assign nmi_fall = nmi_prev_q & ~nmi_s;

`ifdef IRQ_NEST_EN
  logic [7:0] ins_q, ins_d;
  logic [2:0] ins_low;
  logic       wr_stat;

  assign wr_stat  = wr_en & (reg_addr == 2'd3);
  assign ins_low  = lowest8(ins_q);
  assign stat_ins = ins_low;

  // Only channels more urgent than the highest in-service level may interrupt.
  always_comb begin
    elig = '1;
    if (ins_q != 8'h00) begin
      for (int i = 0; i < CHANNELS; i++) begin
        elig[i] = (i < int'(ins_low));
      end
    end
  end

  // EOI retires the most urgent in-service level; an acknowledge opens a new one.
  always_comb begin
    ins_d = ins_q;
    if (wr_stat && (ins_q != 8'h00)) ins_d[ins_low] = 1'b0;
    if (ack_ok) ins_d[vec_q] = 1'b1;
  end

  // In-service register.
  always_ff @(posedge phi2 or posedge res) begin
    if (res) ins_q <= 8'h00;
    else     ins_q <= ins_d;
  end
`else
  assign elig     = '1;
  assign stat_ins = 3'd0;
`endif

  // Synchronise the asynchronous request lines and keep the previous synchronised value.
  always_ff @(posedge phi2 or posedge res) begin
    if (res) begin
      for (int k = 0; k < SYNC_STAGES; k++) irq_sync_q[k] <= '1;
      nmi_sync_q <= '1;
      irq_prev_q <= '1;
      nmi_prev_q <= 1'b1;
    end else begin
      irq_sync_q[0] <= irqb_in;
      for (int k = 1; k < SYNC_STAGES; k++) irq_sync_q[k] <= irq_sync_q[k-1];
      nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], nmib_in};
      irq_prev_q <= irq_s;
      nmi_prev_q <= nmi_s;
    end
  end

  // Acknowledge clears only the channel currently reported on vec_idx.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ack_ok && (vec_q == 3'(i))) ack_clr[i] = 1'b1;
    end
  end

  // Next state: level bits follow the line; edge bits latch, and a set beats any clear.
  always_comb begin
    edge_clr   = ack_clr
               | (wr_pend ? wdata_ch  : '0)
               | (wr_mode ? ~wdata_ch : '0);
    pend_d     = (mode_q & (edge_set | (pend_q & ~edge_clr))) | (~mode_q & ~irq_s);
    mask_d     = wr_mask ? wdata_ch : mask_q;
    mode_d     = wr_mode ? wdata_ch : mode_q;
    nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_ack);
    irqb_d     = ~(|act_eff);
    vec_d      = (|act_eff) ? lowest8(8'(act_eff)) : vec_q;
  end

  // Configuration, pending state and registered CPU-side outputs.
  always_ff @(posedge phi2 or posedge res) begin
    if (res) begin
      mask_q     <= '0;
      mode_q     <= '0;
      pend_q     <= '0;
      nmi_pend_q <= 1'b0;
      irqb_q     <= 1'b1;
      nmib_q     <= 1'b1;
      vec_q      <= 3'd0;
    end else begin
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      nmi_pend_q <= nmi_pend_d;
      irqb_q     <= irqb_d;
      nmib_q     <= ~nmi_pend_q;
      vec_q      <= vec_d;
    end
  end

  // Register window read mux; drives zero unless a read is selected.
  always_comb begin
    rdata = 8'h00;
    if (cs && rwb) begin
      case (reg_addr)
        2'd0:    rdata = 8'(mask_q);
        2'd1:    rdata = 8'(mode_q);
        2'd2:    rdata = 8'(pend_q);
        default: rdata = {(|act), nmi_pend_q, stat_ins, vec_q};
      endcase
    end
  end

  assign irqb     = irqb_q;
  assign nmib     = nmib_q;
  assign vec_idx  = vec_q;
  assign vec_addr = VEC_BASE + {12'h000, vec_q, 1'b0};

endmodule

// File: tb/tb_irq_nmi_ctrl.sv
// Scoreboard bench for irq_nmi_ctrl: a behavioural model predicts every cycle,
// stimulus pushes expectations, and a monitor pops and compares them.
module tb_irq_nmi_ctrl;
  localparam int CH = 8;
  localparam int NS = 2;

  logic        phi2 = 1'b0;
  logic        res;
  logic [7:0]  irqb_in;
  logic        nmib_in, cs, rwb, int_ack, nmi_ack;
  logic [1:0]  reg_addr;
  logic [7:0]  wdata, rdata;
  logic        irqb, nmib;
  logic [2:0]  vec_idx;
  logic [15:0] vec_addr;

  irq_nmi_ctrl #(.CHANNELS(CH), .SYNC_STAGES(NS), .VEC_BASE(16'hFFE0)) dut (
    .phi2(phi2), .res(res), .irqb_in(irqb_in), .nmib_in(nmib_in), .cs(cs), .rwb(rwb),
    .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata), .int_ack(int_ack), .nmi_ack(nmi_ack),
    .irqb(irqb), .nmib(nmib), .vec_idx(vec_idx), .vec_addr(vec_addr));

  always #5 phi2 = ~phi2;

  typedef struct {
    int          cyc;
    logic        irqb, nmib;
    logic [2:0]  vec;
    logic [15:0] addr;
    logic [7:0]  rd;
    bit          p_rd;   logic [7:0]  p_rd_v;
    bit          p_irqb; logic        p_irqb_v;
    bit          p_nmib; logic        p_nmib_v;
    bit          p_addr; logic [15:0] p_addr_v;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  // Fixed expectations for the next cycle, taken from the directed plan.
  bit          p_rd = 0, p_irqb = 0, p_nmib = 0, p_addr = 0;
  logic [7:0]  p_rd_v = '0;
  logic        p_irqb_v = 1'b1, p_nmib_v = 1'b1;
  logic [15:0] p_addr_v = '0;

  // Behavioural model state: line history since reset plus architectural registers.
  logic [7:0] irq_hist[$];
  logic       nmi_hist[$];
  logic [7:0] m_mask, m_mode, m_pend, m_ins;
  logic       m_nmi_pend, m_irqb, m_nmib;
  logic [2:0] m_vec;

  function automatic logic [2:0] low8(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Line value as seen by the controller k edges into the post-reset history.
  function automatic logic [7:0] seen_irq(int k);
    if (k < 0) return 8'hFF;
    return irq_hist[k];
  endfunction

  function automatic logic seen_nmi(int k);
    if (k < 0) return 1'b1;
    return nmi_hist[k];
  endfunction

  function automatic logic [7:0] eligible();
`ifdef IRQ_NEST_EN
    if (m_ins == 8'h00) return 8'hFF;
    return 8'((1 << low8(m_ins)) - 1);
`else
    return 8'hFF;
`endif
  endfunction

  function automatic logic [7:0] model_rdata();
    logic [2:0] insf;
    insf = 3'd0;
`ifdef IRQ_NEST_EN
    insf = low8(m_ins);
`endif
    if (!(cs && rwb)) return 8'h00;
    case (reg_addr)
      2'd0:    return m_mask;
      2'd1:    return m_mode;
      2'd2:    return m_pend;
      default: return {((m_pend & m_mask) != 0), m_nmi_pend, insf, m_vec};
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] s, sp, act, np, ni;
    logic       ns, nsp;
    int         n;
    bit         wr, set_b, clr_b;
    if (res) begin
      m_mask = 0; m_mode = 0; m_pend = 0; m_ins = 0;
      m_nmi_pend = 0; m_irqb = 1; m_nmib = 1; m_vec = 0;
      irq_hist.delete(); nmi_hist.delete();
      return;
    end
    n   = irq_hist.size();
    s   = seen_irq(n - NS);
    sp  = seen_irq(n - NS - 1);
    ns  = seen_nmi(n - NS);
    nsp = seen_nmi(n - NS - 1);
    act = m_pend & m_mask & eligible();
    wr  = cs && !rwb;
    for (int i = 0; i < CH; i++) begin
      if (!m_mode[i]) np[i] = !s[i];
      else begin
        set_b = sp[i] && !s[i];
        clr_b = (wr && reg_addr == 2 && wdata[i]) || (int_ack && act != 0 && m_vec == i)
             || (wr && reg_addr == 1 && !wdata[i]);
        np[i] = set_b || (m_pend[i] && !clr_b);
      end
    end
    ni = m_ins;
`ifdef IRQ_NEST_EN
    if (wr && reg_addr == 3 && m_ins != 0) ni[low8(m_ins)] = 1'b0;
    if (int_ack && act != 0) ni[m_vec] = 1'b1;
`endif
    m_nmib = !m_nmi_pend;
    m_nmi_pend = (nsp && !ns) || (m_nmi_pend && !nmi_ack);
    m_irqb = (act == 0);
    if (act != 0) m_vec = low8(act);
    if (wr && reg_addr == 0) m_mask = wdata;
    if (wr && reg_addr == 1) m_mode = wdata;
    m_pend = np;
    m_ins  = ni;
    irq_hist.push_back(irqb_in);
    nmi_hist.push_back(nmib_in);
  endtask

  // One clock: advance the model on the edge, queue its prediction, return at negedge.
  task automatic tick();
    exp_t e;
    @(posedge phi2);
    model_step();
    cyc++;
    e.cyc = cyc; e.irqb = m_irqb; e.nmib = m_nmib; e.vec = m_vec;
    e.addr = 16'hFFE0 + 16'(2 * m_vec); e.rd = model_rdata();
    e.p_rd = p_rd; e.p_rd_v = p_rd_v; e.p_irqb = p_irqb; e.p_irqb_v = p_irqb_v;
    e.p_nmib = p_nmib; e.p_nmib_v = p_nmib_v; e.p_addr = p_addr; e.p_addr_v = p_addr_v;
    p_rd = 0; p_irqb = 0; p_nmib = 0; p_addr = 0;
    sbq.push_back(e);
    @(negedge phi2);
  endtask

  task automatic check(string name, int c, logic [15:0] got, logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h, want %h", name, c, got, want);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued prediction each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge phi2);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("irqb",     e.cyc, 16'(irqb),     16'(e.irqb));
        check("nmib",     e.cyc, 16'(nmib),     16'(e.nmib));
        check("vec_idx",  e.cyc, 16'(vec_idx),  16'(e.vec));
        check("vec_addr", e.cyc, vec_addr,      e.addr);
        check("rdata",    e.cyc, 16'(rdata),    16'(e.rd));
        if (e.p_rd)   check("plan_rdata",    e.cyc, 16'(rdata), 16'(e.p_rd_v));
        if (e.p_irqb) check("plan_irqb",     e.cyc, 16'(irqb),  16'(e.p_irqb_v));
        if (e.p_nmib) check("plan_nmib",     e.cyc, 16'(nmib),  16'(e.p_nmib_v));
        if (e.p_addr) check("plan_vec_addr", e.cyc, vec_addr,   e.p_addr_v);
      end
    end
  end

  task automatic bus_idle();
    cs = 0; rwb = 1; reg_addr = 0; wdata = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1; rwb = 0; reg_addr = a; wdata = d;
    tick();
    bus_idle();
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] want);
    cs = 1; rwb = 1; reg_addr = a;
    p_rd = 1; p_rd_v = want;
    tick();
    bus_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1; irqb_in = 8'hFF; nmib_in = 1; int_ack = 0; nmi_ack = 0;
    bus_idle();
    @(negedge phi2);
    p_irqb = 1; p_irqb_v = 1; p_nmib = 1; p_nmib_v = 1;
    repeat (3) tick();
    res = 0;

    // Reset state of the register window.
    for (int a = 0; a < 4; a++) rd(2'(a), 8'h00);

    // Level mode on channel 2: four-edge latency on assert and release.
    wr(0, 8'h04);
    irqb_in[2] = 0;
    for (int k = 1; k <= 4; k++) begin p_irqb = 1; p_irqb_v = (k < 4); tick(); end
    p_addr = 1; p_addr_v = 16'hFFE4;
    rd(3, 8'h82);
    irqb_in[2] = 1;
    for (int k = 1; k <= 4; k++) begin p_irqb = 1; p_irqb_v = (k == 4); tick(); end

    // Edge mode on channel 0: a one-cycle pulse latches; int_ack clears it.
    wr(0, 8'h00); wr(1, 8'h01); wr(0, 8'h01);
    irqb_in[0] = 0; tick(); irqb_in[0] = 1;
    repeat (4) tick();
    rd(2, 8'h01);
    int_ack = 1; tick(); int_ack = 0;
    tick();
    p_irqb = 1; p_irqb_v = 1;
    rd(2, 8'h00);

    // Priority between channels 1 and 5, then W1C of channel 1.
    wr(1, 8'h22); wr(0, 8'h22);
    irqb_in[1] = 0; irqb_in[5] = 0; tick(); irqb_in[1] = 1; irqb_in[5] = 1;
    repeat (4) tick();
    rd(3, 8'h81);
    wr(2, 8'h02);
    tick();
    rd(3, 8'h85);
    wr(2, 8'h20); wr(0, 8'h00); wr(1, 8'h00);

    // NMI held low fires once; ack releases it for good.
    nmib_in = 0;
    for (int k = 1; k <= 20; k++) begin p_nmib = 1; p_nmib_v = (k < 4); tick(); end
    nmi_ack = 1; tick(); nmi_ack = 0;
    for (int k = 1; k <= 11; k++) begin p_nmib = 1; p_nmib_v = 1; tick(); end
    // A new falling edge coinciding with nmi_ack keeps the NMI pending.
    nmib_in = 1; repeat (4) tick();
    nmib_in = 0; tick(); tick();
    nmi_ack = 1; tick(); nmi_ack = 0;
    for (int k = 1; k <= 5; k++) begin p_nmib = 1; p_nmib_v = 0; tick(); end
    nmi_ack = 1; tick(); nmi_ack = 0; nmib_in = 1;
    repeat (4) tick();

`ifdef IRQ_NEST_EN
    // Nesting: ack channel 3, then a lower-priority channel is held off.
    wr(1, 8'h00); wr(0, 8'hFF);
    irqb_in[3] = 0; repeat (4) tick();
    int_ack = 1; tick(); int_ack = 0; irqb_in[3] = 1;
    repeat (5) tick();
    irqb_in[6] = 0;
    for (int k = 1; k <= 6; k++) begin p_irqb = 1; p_irqb_v = 1; tick(); end
    irqb_in[1] = 0; repeat (3) tick();
    p_irqb = 1; p_irqb_v = 0; tick();
    rd(3, 8'h99);
    wr(3, 8'h00);
    rd(3, 8'h81);
    irqb_in = 8'hFF; wr(0, 8'h00);
    repeat (4) tick();
`endif

    // Randomised traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < CH; b++) if ($urandom_range(0, 11) == 0) irqb_in[b] = ~irqb_in[b];
      if ($urandom_range(0, 19) == 0) nmib_in = ~nmib_in;
      cs       = ($urandom_range(0, 3) == 0);
      rwb      = 1'($urandom_range(0, 1));
      reg_addr = 2'($urandom_range(0, 3));
      wdata    = 8'($urandom);
      int_ack  = ($urandom_range(0, 15) == 0);
      nmi_ack  = ($urandom_range(0, 11) == 0);
      tick();
    end
    bus_idle(); int_ack = 0; nmi_ack = 0;
    repeat (3) tick();

    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge phi2);
    #2;
    if (sbq.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d queued, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/irq_nmi_ctrl.md
Name: irq_nmi_ctrl

Overview:
- Parametrised interrupt front-end for the 65C02 core.
- Merges up to 8 active-low peripheral interrupt lines and one NMI line into the CPU's single `irqb` and `nmib` inputs.
- Adds per-channel masking, level/edge mode, fixed priority, vector-index reporting and acknowledge handshakes.
- Sits between peripherals and the CPU; programmed through a 4-byte register window on the CPU data bus.

Parameters:
- CHANNELS, 8, number of IRQ sources (1..8).
- SYNC_STAGES, 2, synchroniser depth on every async input (2..4).
- VEC_BASE, 16'hFFE0, base of the per-channel vector table; channel i vector address = VEC_BASE + 2*i.

Ports:
- phi2  input  1  system clock; all logic on rising edge.
- res  input  1  asynchronous active-high reset.
- irqb_in  input  CHANNELS  peripheral interrupt requests, active low, asynchronous.
- nmib_in  input  1  NMI request, active low, asynchronous, falling-edge sensitive.
- cs  input  1  register window select.
- rwb  input  1  1 = read, 0 = write.
- reg_addr  input  2  register select.
- wdata  input  8  write data.
- rdata  output  8  read data; combinational; 0 when not (cs & rwb).
- int_ack  input  1  one-cycle pulse; CPU has fetched the IRQ vector.
- nmi_ack  input  1  one-cycle pulse; CPU has fetched the NMI vector.
- irqb  output  1  to CPU, active low, registered.
- nmib  output  1  to CPU, active low, registered.
- vec_idx  output  3  highest-priority active channel, registered.
- vec_addr  output  16  VEC_BASE + 2*vec_idx.

Behaviour:
- Reset (async, res=1):
  - MASK, MODE, pending, ack_idx and in-service cleared.
  - Synchroniser flops set to 1.
  - irqb=1, nmib=1, vec_idx=0, nmi_pend=0.
- Synchronisers: every async input passes through SYNC_STAGES flops; s_i is the last stage.
- Pending, channel i (registered):
  - Level mode (MODE[i]=0): pend[i] <= ~s_i.
  - Edge mode (MODE[i]=1): pend[i] set on s_i falling (s_prev=1, s_i=0); cleared by W1C or int_ack.
  - A set in the same cycle as a clear wins.
- Active set: act = pend & MASK.
  - Masked edge bits stay latched and fire when unmasked.
- Priority: lowest index wins.
  - vec_idx <= index of lowest set bit of act; holds its last value when act=0.
  - irqb <= ~|act.
- Latency: irqb_in[i] low before rising edge 1 gives irqb=0 after edge SYNC_STAGES+2, in both modes.
- int_ack: captures vec_idx into ack_idx; clears pend[vec_idx] if that channel is in edge mode. Ignored when act=0.
- NMI:
  - nmi_pend set on falling edge of synchronised nmib_in; nmib <= ~nmi_pend.
  - nmi_ack clears nmi_pend; a new edge in the same cycle keeps it set.
  - Holding nmib_in low produces exactly one NMI.
- Register map (reg_addr); bits [7:CHANNELS] read 0 and ignore writes:
  - 0: MASK, rw, 1 = enabled.
  - 1: MODE, rw, 1 = edge. Switching a channel from edge to level clears its edge pending bit.
  - 2: PEND read = pend. Write: 1 clears edge-mode bits; level-mode bits unaffected.
  - 3: STAT read = {|act, nmi_pend, 3'b0, vec_idx}. Write = EOI (see Optional Feature), otherwise ignored.
- Writes take effect on the rising edge with cs=1, rwb=0.
- A write and a hardware set on the same bit in the same cycle: hardware set wins.

Optional Feature:
- Macro: IRQ_NEST_EN.
- Defined:
  - 8-bit in-service register INS; int_ack sets INS[vec_idx].
  - Only act channels with index lower than the lowest set INS bit drive irqb/vec_idx.
  - Write to reg 3 (EOI) clears the lowest set INS bit.
  - Reg 3 read bits [5:3] = index of the lowest set INS bit; 0 when INS=0.
- Undefined: no INS; every act channel drives irqb; reg 3 writes ignored; STAT[5:3]=0.

Test Plan:
- Reset with all inputs idle, then read regs 0..3 → all 0x00; irqb=1, nmib=1.
- MASK=0x04, level mode, irqb_in[2] low → irqb=0 after 4 edges; STAT=0x82; vec_addr=16'hFFE4; irqb_in[2] high → irqb=1 after 4 edges.
- MODE=0x01, MASK=0x01, 1-cycle low pulse on irqb_in[0] → PEND=0x01 latched; int_ack → PEND=0x00, irqb=1.
- Channels 1 and 5 both active → vec_idx=1; W1C channel 1 → vec_idx=5.
- Hold nmib_in low 20 cycles → nmib=0 once; nmi_ack → nmib=1 and stays 1; nmi_ack on the same cycle as a new edge → nmib stays 0.
- IRQ_NEST_EN: ack channel 3, then channel 6 asserts → irqb stays 1; channel 1 asserts → irqb=0; EOI → INS=0x00.
